chacha_cfg_bank: RTL

CHACHA_CFG_BANK -- requirements
Module: chacha_cfg_bank

---
 rtl/chacha_cfg_bank.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/chacha_cfg_bank.sv
// SPI-driven configuration bank for a ChaCha core: stores key, nonce and block
// position, reads them back over SPI, and issues start/status commands.
module chacha_cfg_bank #(
    parameter int unsigned KEY_BYTES   = 32,
    parameter int unsigned NONCE_BYTES = 12,
    parameter int unsigned POS_BYTES   = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     o_RX_DV,
    input  logic [7:0]               o_RX_Byte,
    output logic                     i_TX_DV,
    output logic [7:0]               i_TX_Byte,
    input  logic                     i_Core_Busy,
    input  logic                     i_Block_Done,
    output logic [8*KEY_BYTES-1:0]   o_Key,
    output logic [8*NONCE_BYTES-1:0] o_Nonce,
    output logic [8*POS_BYTES-1:0]   o_Pos,
    output logic                     o_Start,
    output logic                     o_Err
);

    localparam int unsigned KN_MAX    = (KEY_BYTES > NONCE_BYTES) ? KEY_BYTES : NONCE_BYTES;
    localparam int unsigned MAX_BYTES = (KN_MAX > POS_BYTES) ? KN_MAX : POS_BYTES;
    localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 1);
    localparam int unsigned KW        = 8 * KEY_BYTES;
    localparam int unsigned NW        = 8 * NONCE_BYTES;
    localparam int unsigned PW        = 8 * POS_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_KEY,
        ST_WR_NONCE,
        ST_WR_POS,
        ST_RD_KEY,
        ST_RD_NONCE,
        ST_RD_POS
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [KW-1:0]    key_d;
    logic [NW-1:0]    nonce_d;
    logic [PW-1:0]    pos_d;
    logic             tx_dv_d;
    logic [7:0]       tx_byte_d;
    logic             start_d;
    logic             err_d;
    logic             pos_wr;

    // State and all registered outputs
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            o_Key     <= '0;
            o_Nonce   <= '0;
            o_Pos     <= '0;
            i_TX_DV   <= 1'b0;
            i_TX_Byte <= 8'h00;
            o_Start   <= 1'b0;
            o_Err     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            o_Key     <= key_d;
            o_Nonce   <= nonce_d;
            o_Pos     <= pos_d;
            i_TX_DV   <= tx_dv_d;
            i_TX_Byte <= tx_byte_d;
            o_Start   <= start_d;
            o_Err     <= err_d;
        end
    end

    // Command decode, byte transfers and position counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_nxt   = cnt_q + CNT_W'(1);
        key_d     = o_Key;
        nonce_d   = o_Nonce;
        pos_d     = o_Pos;
        tx_dv_d   = 1'b0;
        tx_byte_d = i_TX_Byte;
        start_d   = 1'b0;
        err_d     = o_Err;
        pos_wr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (o_RX_DV) begin
                    cnt_d = '0;
                    case (o_RX_Byte)
                        8'h01: state_d = ST_WR_KEY;
                        8'h02: state_d = ST_WR_NONCE;
                        8'h03: state_d = ST_WR_POS;
                        8'h04: begin
                            tx_dv_d   = 1'b1;
                            tx_byte_d = o_Key[7:0];
                            if (KEY_BYTES > 1) state_d = ST_RD_KEY;
                        end
                        8'h05: begin
                            tx_dv_d   = 1'b1;
                            tx_byte_d = o_Nonce[7:0];
                            if (NONCE_BYTES > 1) state_d = ST_RD_NONCE;
                        end
                        8'h06: begin
                            tx_dv_d   = 1'b1;
                            tx_byte_d = o_Pos[7:0];
                            if (POS_BYTES > 1) state_d = ST_RD_POS;
                        end
                        8'h07: begin
                            if (i_Core_Busy) err_d   = 1'b1;
                            else             start_d = 1'b1;
                        end
                        8'h08: begin
                            tx_dv_d   = 1'b1;
                            tx_byte_d = {6'b0, o_Err, i_Core_Busy};
                            err_d     = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WR_KEY: begin
                if (o_RX_DV) begin
                    for (int k = 0; k < int'(KEY_BYTES); k++)
                        if (cnt_q == CNT_W'(k)) key_d[8*k +: 8] = o_RX_Byte;
                    cnt_d = cnt_nxt;
                    if (cnt_q == CNT_W'(KEY_BYTES - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WR_NONCE: begin
                if (o_RX_DV) begin
                    for (int k = 0; k < int'(NONCE_BYTES); k++)
                        if (cnt_q == CNT_W'(k)) nonce_d[8*k +: 8] = o_RX_Byte;
                    cnt_d = cnt_nxt;
                    if (cnt_q == CNT_W'(NONCE_BYTES - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WR_POS: begin
                if (o_RX_DV) begin
                    pos_wr = 1'b1;
                    for (int k = 0; k < int'(POS_BYTES); k++)
                        if (cnt_q == CNT_W'(k)) pos_d[8*k +: 8] = o_RX_Byte;
                    cnt_d = cnt_nxt;
                    if (cnt_q == CNT_W'(POS_BYTES - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            // In read states cnt_q is the index of the byte last emitted
            ST_RD_KEY: begin
                if (o_RX_DV) begin
                    tx_dv_d = 1'b1;
                    for (int k = 0; k < int'(KEY_BYTES); k++)
                        if (cnt_nxt == CNT_W'(k)) tx_byte_d = o_Key[8*k +: 8];
                    cnt_d = cnt_nxt;
                    if (cnt_nxt == CNT_W'(KEY_BYTES - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RD_NONCE: begin
                if (o_RX_DV) begin
                    tx_dv_d = 1'b1;
                    for (int k = 0; k < int'(NONCE_BYTES); k++)
                        if (cnt_nxt == CNT_W'(k)) tx_byte_d = o_Nonce[8*k +: 8];
                    cnt_d = cnt_nxt;
                    if (cnt_nxt == CNT_W'(NONCE_BYTES - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RD_POS: begin
                if (o_RX_DV) begin
                    tx_dv_d = 1'b1;
                    for (int k = 0; k < int'(POS_BYTES); k++)
                        if (cnt_nxt == CNT_W'(k)) tx_byte_d = o_Pos[8*k +: 8];
                    cnt_d = cnt_nxt;
                    if (cnt_nxt == CNT_W'(POS_BYTES - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A host position write in the same cycle suppresses the increment
        if (i_Block_Done && !pos_wr) pos_d = o_Pos + PW'(1);
    end

endmodule
